// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//
// Shared definitions for the pipeline hazard controller of the 5-stage
// in-order core.
//   - pipe_ctrl_state_e : scheduler states (RUN, FLUSH, MDU_WAIT, MEM_WAIT)
//   - REG_IDX_WIDTH     : architectural register index width
//   - NOP_INSTR         : canonical NOP encoding (addi x0, x0, 0)
//   - ctrl_out_t        : bundle of every stall/nop/redirect control driven
//                         by the scheduler, plus the canned patterns it uses
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_WIDTH = 5;

    // Wide enough for the largest legal redirect bubble window (15).
    localparam int BUB_CNT_WIDTH = 4;

    // Wide enough for the largest legal memory timeout (65535).
    localparam int TMO_CNT_WIDTH = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MDU_WAIT = 2'd2,
        MEM_WAIT = 2'd3
    } pipe_ctrl_state_e;

    typedef struct packed {
        logic pc_stall;
        logic pc_redirect;
        logic ifid_stall;
        logic ifid_nop;
        logic idex_stall;
        logic idex_nop;
        logic exmem_stall;
        logic exmem_nop;
        logic memwb_nop;
        logic mem_timeout;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_NONE = '0;

    // Everything up to EX/MEM frozen, a bubble handed to WB while MEM waits.
    localparam ctrl_out_t CTRL_MEM_WAIT = '{
        pc_stall:    1'b1,
        ifid_stall:  1'b1,
        idex_stall:  1'b1,
        exmem_stall: 1'b1,
        memwb_nop:   1'b1,
        default:     1'b0
    };

    // Front end and EX frozen, a bubble flows into MEM behind the MDU op.
    localparam ctrl_out_t CTRL_MDU_WAIT = '{
        pc_stall:   1'b1,
        ifid_stall: 1'b1,
        idex_stall: 1'b1,
        exmem_nop:  1'b1,
        default:    1'b0
    };

    // Taken branch: load the new PC and squash the two younger instructions.
    localparam ctrl_out_t CTRL_REDIRECT = '{
        pc_redirect: 1'b1,
        ifid_nop:    1'b1,
        idex_nop:    1'b1,
        default:     1'b0
    };

    // Hold the dependent instruction in ID and insert one bubble into EX.
    localparam ctrl_out_t CTRL_LOAD_USE = '{
        pc_stall:   1'b1,
        ifid_stall: 1'b1,
        idex_nop:   1'b1,
        default:    1'b0
    };

    // Fetch is still returning wrong-path words after a redirect.
    localparam ctrl_out_t CTRL_FLUSH = '{
        ifid_nop: 1'b1,
        default:  1'b0
    };

    localparam ctrl_out_t CTRL_TIMEOUT = '{
        mem_timeout: 1'b1,
        default:     1'b0
    };

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
//
// Combinational register-dependency comparator. Flags when the instruction
// in ID reads a register that a producer further down the pipe will write.
// Kept generic (rd_valid instead of "is load") so the forwarding unit can
// reuse it.
//
// Ports:
//   rs1, rs2         in  ID source register indices
//   rs1_en, rs2_en   in  ID actually reads the corresponding source
//   rd               in  producer destination index
//   rd_valid         in  producer result is of interest (e.g. EX is a load)
//   hazard           out dependency present (x0 never creates one)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_WIDTH-1:0] rs1,
    input  logic [REG_IDX_WIDTH-1:0] rs2,
    input  logic                     rs1_en,
    input  logic                     rs2_en,
    input  logic [REG_IDX_WIDTH-1:0] rd,
    input  logic                     rd_valid,
    output logic                     hazard
);

    logic rs1_match;
    logic rs2_match;

    // Writes to x0 are discarded by the register file, so a destination of
    // zero can never be the source of a real dependency.
    always_comb begin
        rs1_match = rs1_en && (rs1 == rd);
        rs2_match = rs2_en && (rs2 == rd);
        hazard    = rd_valid && (rd != '0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage in-order core. Drives the
// stall/nop controls of the four pipeline registers plus PC hold/redirect,
// resolving (in priority order) LSU wait states, multi-cycle MDU operations,
// taken-branch redirects with a fetch-latency bubble window, and load-use
// hazards. Also aborts over-long memory waits and counts PC-stall cycles.
//
// Parameters:
//   REDIRECT_BUBBLES  IF/ID NOP cycles after a redirect (1..15)
//   MEM_TIMEOUT       max consecutive memory-wait cycles before abort (2..65535)
//   CNT_WIDTH         width of the saturating stall-cycle counter
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_id_rs1/rs2, i_id_rs1/2_en   ID source registers and their read enables
//   i_ex_rd, i_ex_is_load         EX destination and load flag
//   i_ex_redirect                 EX taken branch/jump (level)
//   i_mdu_start, i_mdu_done       MDU launch / result pulses
//   i_lsu_req, i_lsu_ack          MEM access outstanding / complete
//   o_pc_stall, o_pc_redirect     PC hold / load redirect target
//   o_ifid_*, o_idex_*, o_exmem_* pipeline register stall/nop controls
//   o_memwb_nop                   bubble into MEM/WB
//   o_mem_timeout                 one-cycle abort pulse to the trap unit
//   o_stall_cnt                   saturating count of PC-stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 2,
    parameter int MEM_TIMEOUT      = 256,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REG_IDX_WIDTH-1:0] i_id_rs1,
    input  logic [REG_IDX_WIDTH-1:0] i_id_rs2,
    input  logic                     i_id_rs1_en,
    input  logic                     i_id_rs2_en,
    input  logic [REG_IDX_WIDTH-1:0] i_ex_rd,
    input  logic                     i_ex_is_load,
    input  logic                     i_ex_redirect,
    input  logic                     i_mdu_start,
    input  logic                     i_mdu_done,
    input  logic                     i_lsu_req,
    input  logic                     i_lsu_ack,
    output logic                     o_pc_stall,
    output logic                     o_pc_redirect,
    output logic                     o_ifid_stall,
    output logic                     o_ifid_nop,
    output logic                     o_idex_stall,
    output logic                     o_idex_nop,
    output logic                     o_exmem_stall,
    output logic                     o_exmem_nop,
    output logic                     o_memwb_nop,
    output logic                     o_mem_timeout,
    output logic [CNT_WIDTH-1:0]     o_stall_cnt
);

    // With a single-cycle fetch latency the redirect cycle itself already
    // covers the only wrong-path word, so FLUSH is never entered.
    localparam bit USE_FLUSH = (REDIRECT_BUBBLES > 1);

    localparam logic [BUB_CNT_WIDTH-1:0] BUB_LOAD   = BUB_CNT_WIDTH'(REDIRECT_BUBBLES - 1);
    localparam logic [BUB_CNT_WIDTH-1:0] BUB_ONE    = BUB_CNT_WIDTH'(1);
    localparam logic [TMO_CNT_WIDTH-1:0] TMO_ONE    = TMO_CNT_WIDTH'(1);
    localparam logic [TMO_CNT_WIDTH-1:0] TMO_LIMIT  = TMO_CNT_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0]     STALL_ONE  = CNT_WIDTH'(1);

    pipe_ctrl_state_e           state_q;
    pipe_ctrl_state_e           state_nxt;
    logic [BUB_CNT_WIDTH-1:0]   bub_q;
    logic [BUB_CNT_WIDTH-1:0]   bub_nxt;
    logic [TMO_CNT_WIDTH-1:0]   tmo_q;
    logic [TMO_CNT_WIDTH-1:0]   tmo_nxt;
    logic [CNT_WIDTH-1:0]       stall_cnt_q;

    ctrl_out_t                  ctrl;
    ctrl_out_t                  ctrl_out;
    logic                       load_use;
    logic                       mem_wait_req;

    // The EX-stage load is the only producer whose data cannot be forwarded
    // in time, so that is the only case that needs a bubble.
    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .rs1      (i_id_rs1),
        .rs2      (i_id_rs2),
        .rs1_en   (i_id_rs1_en),
        .rs2_en   (i_id_rs2_en),
        .rd       (i_ex_rd),
        .rd_valid (i_ex_is_load),
        .hazard   (load_use)
    );

    assign mem_wait_req = i_lsu_req && !i_lsu_ack;

    // State register plus the bubble and memory-timeout counters. The
    // timeout counter holds the number of wait cycles already spent,
    // including the RUN cycle in which the wait was first seen.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= RUN;
            bub_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_nxt;
            bub_q   <= bub_nxt;
            tmo_q   <= tmo_nxt;
        end
    end

    // Next-state and control decode. Every branch either picks one canned
    // control pattern or leaves all controls low; the older-stage event
    // always wins because it freezes everything younger behind it. In the
    // two wait states EX is frozen, so a redirect or load-use sitting in EX
    // is simply re-presented once the scheduler is back in RUN.
    always_comb begin
        state_nxt = state_q;
        bub_nxt   = bub_q;
        tmo_nxt   = tmo_q;
        ctrl      = CTRL_NONE;

        unique case (state_q)
            RUN: begin
                if (mem_wait_req) begin
                    ctrl      = CTRL_MEM_WAIT;
                    state_nxt = MEM_WAIT;
                    tmo_nxt   = TMO_ONE;
                end else if (i_mdu_start) begin
                    if (!i_mdu_done) begin
                        ctrl      = CTRL_MDU_WAIT;
                        state_nxt = MDU_WAIT;
                    end
                end else if (i_ex_redirect) begin
                    ctrl = CTRL_REDIRECT;
                    if (USE_FLUSH) begin
                        state_nxt = FLUSH;
                        bub_nxt   = BUB_LOAD;
                    end
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end

            FLUSH: begin
                if (mem_wait_req) begin
                    ctrl      = CTRL_MEM_WAIT;
                    state_nxt = MEM_WAIT;
                    bub_nxt   = '0;
                    tmo_nxt   = TMO_ONE;
                end else if (i_ex_redirect) begin
                    ctrl    = CTRL_REDIRECT;
                    bub_nxt = BUB_LOAD;
                end else begin
                    ctrl    = CTRL_FLUSH;
                    bub_nxt = bub_q - BUB_ONE;
                    if (bub_q <= BUB_ONE) begin
                        state_nxt = RUN;
                        bub_nxt   = '0;
                    end
                end
            end

            MDU_WAIT: begin
                if (i_mdu_done) begin
                    state_nxt = RUN;
                end else begin
                    ctrl = CTRL_MDU_WAIT;
                end
            end

            MEM_WAIT: begin
                if (i_lsu_ack) begin
                    state_nxt = RUN;
                    tmo_nxt   = '0;
                end else if (tmo_q >= TMO_LIMIT) begin
                    ctrl      = CTRL_TIMEOUT;
                    state_nxt = RUN;
                    tmo_nxt   = '0;
                end else begin
                    ctrl    = CTRL_MEM_WAIT;
                    tmo_nxt = tmo_q + TMO_ONE;
                end
            end

            default: begin
                state_nxt = RUN;
                bub_nxt   = '0;
                tmo_nxt   = '0;
            end
        endcase
    end

    // Controls are purely combinational, so they are forced low while reset
    // is held to keep the pipeline registers from acting on stale state.
    assign ctrl_out = i_rst ? CTRL_NONE : ctrl;

    // Performance counter of PC-stall cycles; sticks at all-ones rather than
    // wrapping so a long run never reports a misleadingly small number.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else if (ctrl_out.pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_ONE;
        end
    end

    assign o_pc_stall    = ctrl_out.pc_stall;
    assign o_pc_redirect = ctrl_out.pc_redirect;
    assign o_ifid_stall  = ctrl_out.ifid_stall;
    assign o_ifid_nop    = ctrl_out.ifid_nop;
    assign o_idex_stall  = ctrl_out.idex_stall;
    assign o_idex_nop    = ctrl_out.idex_nop;
    assign o_exmem_stall = ctrl_out.exmem_stall;
    assign o_exmem_nop   = ctrl_out.exmem_nop;
    assign o_memwb_nop   = ctrl_out.memwb_nop;
    assign o_mem_timeout = ctrl_out.mem_timeout;
    assign o_stall_cnt   = stall_cnt_q;

endmodule
